// File: rtl/aig_tt_sweeper.sv
// aig_tt_sweeper: exhaustive truth-table sweeper for a small combinational AIG.
// Issues every input pattern once and captures the single output into tt.
// Each captured bit is compared against a latched expected table, which yields
// a mismatch count and the lowest failing pattern index.
module aig_tt_sweeper #(
  parameter int NPI      = 5,
  parameter int EVAL_LAT = 0,
  localparam int TT      = 1 << NPI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TT-1:0]     exp_tt,
  output logic [NPI-1:0]    pat,
  output logic              pat_valid,
  input  logic              po,
  output logic              busy,
  output logic              done,
  output logic [TT-1:0]     tt,
  output logic [NPI:0]      mism_cnt,
  output logic [NPI-1:0]    first_mis,
  output logic              mis_found
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [NPI-1:0] ONE_PAT = 1;
  localparam logic [NPI:0]   ONE_CNT = 1;

  state_t          state;
  logic [TT-1:0]   exp_q;
  logic            flush;
  logic            cap_v;
  logic [NPI-1:0]  cap_i;

  // An abort only counts while a sweep or drain is running.
  assign flush = abort && busy;

  // Tag line: the (valid, index) tag that lines up with po on the current edge.
  generate
    if (EVAL_LAT == 0) begin : g_no_delay
      assign cap_v = pat_valid;
      assign cap_i = pat;
    end else begin : g_delay
      logic [EVAL_LAT-1:0] dly_v;
      logic [NPI-1:0]      dly_i [EVAL_LAT];

      // Shift the issued pattern tag along with the evaluation pipeline.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          dly_v <= '0;
          for (int j = 0; j < EVAL_LAT; j++) begin
            dly_i[j] <= '0;
          end
        end else begin
          dly_v[0] <= pat_valid;
          dly_i[0] <= pat;
          for (int j = 1; j < EVAL_LAT; j++) begin
            dly_v[j] <= dly_v[j-1];
            dly_i[j] <= dly_i[j-1];
          end
        end
      end

      assign cap_v = dly_v[EVAL_LAT-1];
      assign cap_i = dly_i[EVAL_LAT-1];
    end
  endgenerate

  // Sequencer FSM: pattern issue, capture/compare and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      exp_q     <= '0;
      pat       <= '0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tt        <= '0;
      mism_cnt  <= '0;
      first_mis <= '0;
      mis_found <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= exp_tt;
            tt        <= '0;
            mism_cnt  <= '0;
            first_mis <= '0;
            mis_found <= 1'b0;
            pat       <= '0;
            pat_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP, DRAIN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pat_valid <= 1'b0;
          end else begin
            if (state == SWEEP) begin
              if (&pat) begin
                pat_valid <= 1'b0;
                state     <= DRAIN;
              end else begin
                pat <= pat + ONE_PAT;
              end
            end
            if (cap_v) begin
              tt[cap_i] <= po;
              if (po != exp_q[cap_i]) begin
                mism_cnt <= mism_cnt + ONE_CNT;
                if (!mis_found) begin
                  first_mis <= cap_i;
                  mis_found <= 1'b1;
                end
              end
              if (&cap_i) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pat_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// tb_aig_tt_sweeper: directed bench for aig_tt_sweeper.
// One instance evaluates the AIG combinationally (EVAL_LAT=0); a second sees
// it behind two register stages (EVAL_LAT=2). The AIG is (pi0&pi1)|(pi2&pi3).
module tb_aig_tt_sweeper;

  localparam int NPI = 5;
  localparam int TT  = 1 << NPI;
  localparam logic [31:0] GOLD_TT = 32'hF888F888;

  logic            clk;
  logic            rst;
  logic [TT-1:0]   exp_tt;

  logic            start0, abort0, po0;
  logic [NPI-1:0]  pat0;
  logic            pat_valid0, busy0, done0, mis_found0;
  logic [TT-1:0]   tt0;
  logic [NPI:0]    mism_cnt0;
  logic [NPI-1:0]  first_mis0;

  logic            start2, abort2, po2;
  logic [NPI-1:0]  pat2;
  logic            pat_valid2, busy2, done2, mis_found2;
  logic [TT-1:0]   tt2;
  logic [NPI:0]    mism_cnt2;
  logic [NPI-1:0]  first_mis2;
  logic [NPI-1:0]  stage1, stage2;

  int total;
  int bad;

  aig_tt_sweeper #(.NPI(NPI), .EVAL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .exp_tt(exp_tt),
    .pat(pat0), .pat_valid(pat_valid0), .po(po0), .busy(busy0), .done(done0),
    .tt(tt0), .mism_cnt(mism_cnt0), .first_mis(first_mis0), .mis_found(mis_found0)
  );

  aig_tt_sweeper #(.NPI(NPI), .EVAL_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .exp_tt(exp_tt),
    .pat(pat2), .pat_valid(pat_valid2), .po(po2), .busy(busy2), .done(done2),
    .tt(tt2), .mism_cnt(mism_cnt2), .first_mis(first_mis2), .mis_found(mis_found2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational AIG for the zero-latency instance.
  assign po0 = (pat0[0] & pat0[1]) | (pat0[2] & pat0[3]);

  // Two register stages in front of the AIG for the latency-2 instance.
  always @(posedge clk) begin
    stage1 <= pat2;
    stage2 <= stage1;
  end
  assign po2 = (stage2[0] & stage2[1]) | (stage2[2] & stage2[3]);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Pulse start on the chosen instance with the given expected table.
  task automatic applyStimulus(input int which, input logic [31:0] exp_val);
    exp_tt = exp_val;
    if (which == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count cycles until done is seen, bounded.
  task automatic waitDone(input int which, output int cycles);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = (which == 0) ? done0 : done2;
    end
    if (!seen) checkOutput("done_timeout", 64'(n), 64'd0);
    cycles = n;
  endtask

  initial begin
    int cyc;
    int done_seen;
    total = 0;
    bad = 0;
    rst = 1'b1;
    exp_tt = '0;
    start0 = 1'b0; abort0 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dut0", 64'({pat0, pat_valid0, busy0, done0, tt0, mism_cnt0, first_mis0, mis_found0}), 64'd0);
    checkOutput("reset_dut2", 64'({pat2, pat_valid2, busy2, done2, tt2, mism_cnt2, first_mis2, mis_found2}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Exact match: patterns 0..31 on consecutive cycles, done 32 cycles after start.
    applyStimulus(0, GOLD_TT);
    for (int k = 0; k < TT; k++) begin
      checkOutput($sformatf("pat_%0d", k), 64'({pat_valid0, pat0}), 64'({1'b1, 5'(k)}));
      if (k == TT - 1) checkOutput("busy_last", 64'({busy0, done0}), 64'b10);
      @(posedge clk);
      #1;
    end
    checkOutput("done_at_32", 64'({done0, busy0, pat_valid0}), 64'b100);
    checkOutput("match_tt", 64'(tt0), 64'(GOLD_TT));
    checkOutput("match_cnt", 64'(mism_cnt0), 64'd0);
    checkOutput("match_found", 64'({mis_found0, first_mis0}), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done0), 64'd0);
    checkOutput("result_hold", 64'(tt0), 64'(GOLD_TT));

    // Two mismatches at patterns 0 and 31.
    applyStimulus(0, 32'h7888F889);
    waitDone(0, cyc);
    checkOutput("mis_cycles", 64'(cyc), 64'd32);
    checkOutput("mis_cnt", 64'(mism_cnt0), 64'd2);
    checkOutput("mis_first", 64'(first_mis0), 64'd0);
    checkOutput("mis_found", 64'(mis_found0), 64'd1);
    checkOutput("mis_tt", 64'(tt0), 64'(GOLD_TT));

    // Latency-2 path.
    applyStimulus(2, GOLD_TT);
    waitDone(2, cyc);
    checkOutput("lat2_cycles", 64'(cyc), 64'd34);
    checkOutput("lat2_tt", 64'(tt2), 64'(GOLD_TT));
    checkOutput("lat2_cnt", 64'(mism_cnt2), 64'd0);
    checkOutput("lat2_found", 64'(mis_found2), 64'd0);

    // Abort 10 cycles after start, then a clean rerun.
    applyStimulus(0, GOLD_TT);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    abort0 = 1'b0;
    checkOutput("abort_idle", 64'({busy0, pat_valid0, done0}), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done0) done_seen++;
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    applyStimulus(0, GOLD_TT);
    waitDone(0, cyc);
    checkOutput("rerun_cycles", 64'(cyc), 64'd32);
    checkOutput("rerun_tt", 64'(tt0), 64'(GOLD_TT));
    checkOutput("rerun_res", 64'({mism_cnt0, mis_found0, first_mis0}), 64'd0);

    // Reset mid-sweep at pattern 20.
    applyStimulus(0, 32'h0000FFFF);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pat_20", 64'(pat0), 64'd20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid", 64'({pat0, pat_valid0, busy0, done0, tt0, mism_cnt0, first_mis0, mis_found0}), 64'd0);

    // Start during a busy sweep is ignored, including its exp_tt.
    applyStimulus(0, GOLD_TT);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    exp_tt = 32'h0;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    waitDone(0, cyc);
    checkOutput("busy_start_cycles", 64'(cyc), 64'd26);
    checkOutput("busy_start_cnt", 64'(mism_cnt0), 64'd0);
    checkOutput("busy_start_found", 64'(mis_found0), 64'd0);

    // Back-to-back: start in the done cycle with an all-zero expected table.
    applyStimulus(0, 32'h0);
    checkOutput("b2b_begin", 64'({busy0, pat_valid0, pat0}), 64'({2'b11, 5'd0}));
    waitDone(0, cyc);
    checkOutput("b2b_cycles", 64'(cyc), 64'd32);
    checkOutput("b2b_cnt", 64'(mism_cnt0), 64'd14);
    checkOutput("b2b_first", 64'(first_mis0), 64'd3);
    checkOutput("b2b_found", 64'(mis_found0), 64'd1);
    checkOutput("b2b_tt", 64'(tt0), 64'(GOLD_TT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aig_tt_sweeper.md
# aig_tt_sweeper

Exhaustive-simulation sequencer for the small combinational AIG netlists that ABC writes out, such as the 5-input `MiniAig`. It sweeps every input pattern into the netlist and collects the single primary output into a truth table. It compares that table against an expected table and reports the mismatch count and the first failing pattern. It sits between a test/config master (start/abort, expected table) and one combinational AIG instance. It may also feed an optional registered wrapper of that instance.

## Interface
- NPI, default 5: number of primary inputs; truth table width TT = 2^NPI.
- EVAL_LAT, default 0, legal range 0..3: register stages between `pat` and `po` in the evaluated path.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel the current sweep; honoured only when busy.
- exp_tt  in  TT  expected truth table; bit k is the expected po for pattern k; sampled on the accepted start edge.
- pat  out  NPI  pattern to the AIG; pat[i] drives pi<i>.
- pat_valid  out  1  pat is a live sweep pattern.
- po  in  1  AIG output for the pattern issued EVAL_LAT cycles earlier.
- busy  out  1  sweep or drain in progress.
- done  out  1  one-cycle pulse: results final.
- tt  out  TT  captured truth table.
- mism_cnt  out  NPI+1  number of bit positions where tt differs from the expected table.
- first_mis  out  NPI  lowest failing pattern index; 0 when there is no mismatch.
- mis_found  out  1  at least one mismatch seen.

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
- IDLE → SWEEP on start. On that edge:
  - latch exp_tt;
  - clear tt, mism_cnt, first_mis and mis_found;
  - set idx=0.
- SWEEP behaviour:
  - pat=idx and pat_valid=1 every cycle;
  - idx increments each edge;
  - after issuing idx=TT-1, go to DRAIN (idx wraps to 0 and is not reissued).
- Tag pipeline: a delay line EVAL_LAT+1 deep carries (valid, idx) alongside the AIG path.
  - When a valid tag emerges at index k, sample po on that edge.
  - Write tt[k] <= po.
  - If po != exp[k], increment mism_cnt.
  - If mis_found was 0 at that point, set first_mis=k and mis_found=1.
- DRAIN behaviour: pat_valid=0 and pat holds its last value. When the capture of pattern TT-1 happens:
  - go to IDLE;
  - assert done for the following cycle.
- Result outputs hold until the next accepted start or rst.
- mism_cnt cannot overflow: its maximum is TT, which fits in NPI+1 bits.
- abort while busy:
  - next state is IDLE and the delay line is flushed;
  - captures still in flight are discarded;
  - done is not pulsed and partial results remain visible.
- abort and start asserted on the same edge in IDLE: start wins and abort is ignored.
- start while busy is ignored; exp_tt is not re-sampled.
- rst at any time clears everything:
  - state goes to IDLE and the delay line is flushed;
  - all outputs are 0: pat, pat_valid, busy, done, tt, mism_cnt, first_mis, mis_found.

## Timing
- Let E0 be the edge that accepts start.
- Pattern k is presented between E(k) and E(k+1).
- Its po is sampled at E(k+1+EVAL_LAT).
- busy: high from E0 up to E(TT+EVAL_LAT), low from that edge on.
- done: high for exactly the one cycle after E(TT+EVAL_LAT).
  - Start-to-done is TT+EVAL_LAT cycles: 32 for NPI=5, EVAL_LAT=0.
- tt, mism_cnt, first_mis and mis_found are final when done is high.
- start asserted during the done cycle is accepted: back-to-back sweeps, no idle gap required.
- Reset values of all outputs are 0.

## Test plan
- Exact match, NPI=5, EVAL_LAT=0:
  - stimulus: DUT po=(pi0&pi1)|(pi2&pi3), exp_tt=0xF888F888, pulse start;
  - response: pat 0..31 on consecutive cycles, done 32 cycles after start, tt=0xF888F888, mism_cnt=0, mis_found=0, first_mis=0.
- Mismatches:
  - stimulus: same DUT, exp_tt=0x7888F889;
  - response: mism_cnt=2, first_mis=0, mis_found=1, tt=0xF888F888.
- Latency: EVAL_LAT=2 with the AIG behind two register stages, exp_tt=0xF888F888 → done 34 cycles after start, tt=0xF888F888, mism_cnt=0.
- Abort:
  - stimulus: abort 10 cycles after start;
  - response: busy=0 and pat_valid=0 the next cycle, no done pulse;
  - follow-up: a new start yields the full clean result of the first scenario.
- Reset and ignored start:
  - stimulus: rst mid-sweep at pattern 20;
  - response: all outputs 0 the next cycle;
  - stimulus: start during a busy sweep with a different exp_tt;
  - response: ignored, results match the originally latched exp_tt.
- Back-to-back:
  - stimulus: start asserted in the done cycle with exp_tt=0;
  - response: second sweep begins immediately, ending with mism_cnt=14, first_mis=3.
